// File: rtl/lisp_eval_engine_pkg.sv
// Shared Lisp word definitions: tags, primitive codes, error codes and
// helpers to build/split tagged words at the default 16-bit word size.
package lisp_defs;

    localparam int LISP_WORD_W = 16;
    localparam int LISP_TAG_W  = 3;
    localparam int LISP_PAY_W  = LISP_WORD_W - LISP_TAG_W;

    typedef enum logic [LISP_TAG_W-1:0] {
        TAG_NIL  = 3'd0,
        TAG_INT  = 3'd1,
        TAG_CONS = 3'd2,
        TAG_PRIM = 3'd3
    } tag_e;

    localparam int PRIM_ADD = 0;
    localparam int PRIM_SUB = 1;
    localparam int PRIM_MUL = 2;

    localparam logic [15:0] ERR_BAD_TAG    = 16'hE001;
    localparam logic [15:0] ERR_NOT_PRIM   = 16'hE002;
    localparam logic [15:0] ERR_BAD_PRIM   = 16'hE003;
    localparam logic [15:0] ERR_BAD_LIST   = 16'hE004;
    localparam logic [15:0] ERR_NOT_INT    = 16'hE005;
    localparam logic [15:0] ERR_STACK_FULL = 16'hE006;

    localparam logic [LISP_WORD_W-1:0] LISP_NIL = '0;

    function automatic logic [LISP_WORD_W-1:0] lisp_pack(tag_e t, logic [LISP_PAY_W-1:0] p);
        return {t, p};
    endfunction

    function automatic tag_e lisp_tag(logic [LISP_WORD_W-1:0] w);
        return tag_e'(w[LISP_WORD_W-1 -: LISP_TAG_W]);
    endfunction

    function automatic logic [LISP_PAY_W-1:0] lisp_payload(logic [LISP_WORD_W-1:0] w);
        return w[LISP_PAY_W-1:0];
    endfunction

endpackage

// File: rtl/lisp_eval_engine_if.sv
// Memory read port between the evaluator (master) and the word memory (slave).
interface lisp_eval_engine_if #(
    parameter int ADDR_W = 13,
    parameter int WORD_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_data;

    modport master (output mem_req, mem_addr, input  mem_ready, mem_data);
    modport slave  (input  mem_req, mem_addr, output mem_ready, mem_data);
endinterface

// File: rtl/lisp_eval_engine_stack.sv
// lisp_eval_stack: synchronous LIFO of application frames with in-place
// update of the top entry. Frames are opaque W-bit vectors here.
module lisp_eval_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         wr_top_i,
    input  logic [W-1:0] push_data_i,
    input  logic [W-1:0] wr_data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] top_idx, push_idx;

    assign top_idx  = IW'(cnt_q - CW'(1));
    assign push_idx = IW'(cnt_q);
    assign full_o   = (cnt_q == CW'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign top_o    = mem_q[top_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (push_i && !full_o)
            cnt_d = cnt_q + CW'(1);
        else if (pop_i && !empty_o)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Storage needs no reset: the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push_i && !full_o)
            mem_q[push_idx] <= push_data_i;
        else if (wr_top_i && !empty_o)
            mem_q[top_idx] <= wr_data_i;
    end

endmodule

// File: rtl/lisp_eval_engine.sv
// Multi-cycle evaluator for nested (+ - *) applications over tagged cons cells.
// Define LISP_EVAL_MUL_EN to accept the MUL primitive (combinational multiply).
module lisp_eval_engine
    import lisp_defs::*;
#(
    parameter int WORD_W      = 16,
    parameter int TAG_W       = 3,
    parameter int ADDR_W      = 13,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] expr_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] result,
    output logic [15:0]       err_code,
    lisp_eval_engine_if.master mem
);
    localparam int PAY_W = WORD_W - TAG_W;
    localparam logic [1:0] OP_ADD = 2'(PRIM_ADD);
    localparam logic [1:0] OP_SUB = 2'(PRIM_SUB);
`ifdef LISP_EVAL_MUL_EN
    localparam logic [1:0] OP_MUL = 2'(PRIM_MUL);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_EVAL, S_FETCH_OP, S_FETCH_CDR, S_FETCH_ARG, S_RETURN, S_DONE, S_ERROR
    } state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [PAY_W-1:0]  acc;
        logic [ADDR_W-1:0] cur;
        logic              first;
    } frame_t;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] expr_q, expr_d;
    logic [WORD_W-1:0] val_q, val_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [15:0]       err_code_q, err_code_d;

    logic   stk_clr, stk_push, stk_pop, stk_wr, stk_full, stk_empty;
    frame_t push_frame, wr_frame, top_frame;

    logic [TAG_W-1:0] expr_tag, data_tag, val_tag;
    logic [PAY_W-1:0] expr_pay, data_pay, val_pay, fold_acc;
    logic             prim_ok;

    assign expr_tag = expr_q[WORD_W-1 -: TAG_W];
    assign expr_pay = expr_q[PAY_W-1:0];
    assign data_tag = mem.mem_data[WORD_W-1 -: TAG_W];
    assign data_pay = mem.mem_data[PAY_W-1:0];
    assign val_tag  = val_q[WORD_W-1 -: TAG_W];
    assign val_pay  = val_q[PAY_W-1:0];

    lisp_eval_stack #(
        .W     ($bits(frame_t)),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (stk_clr),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .wr_top_i    (stk_wr),
        .push_data_i (push_frame),
        .wr_data_i   (wr_frame),
        .top_o       (top_frame),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_comb begin
        prim_ok = (data_pay == PAY_W'(PRIM_ADD)) || (data_pay == PAY_W'(PRIM_SUB));
`ifdef LISP_EVAL_MUL_EN
        if (data_pay == PAY_W'(PRIM_MUL)) prim_ok = 1'b1;
`endif
    end

    // SUB takes its first argument as the seed, so (- x) = x and (-) = 0.
    always_comb begin
        fold_acc = top_frame.acc;
        case (top_frame.op)
            OP_ADD:  fold_acc = top_frame.acc + val_pay;
            OP_SUB:  fold_acc = top_frame.first ? val_pay : top_frame.acc - val_pay;
`ifdef LISP_EVAL_MUL_EN
            OP_MUL:  fold_acc = top_frame.acc * val_pay;
`endif
            default: fold_acc = top_frame.acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expr_q     <= '0;
            val_q      <= '0;
            result_q   <= '0;
            err_code_q <= '0;
        end else begin
            expr_q     <= expr_d;
            val_q      <= val_d;
            result_q   <= result_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        expr_d     = expr_q;
        val_d      = val_q;
        result_d   = result_q;
        err_code_d = err_code_q;
        stk_clr    = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_wr     = 1'b0;
        push_frame = '0;
        wr_frame   = top_frame;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    expr_d     = expr_in;
                    result_d   = '0;
                    err_code_d = '0;
                    stk_clr    = 1'b1;
                    state_d    = S_EVAL;
                end
            end
            S_EVAL: begin
                if (expr_tag == TAG_W'(TAG_INT) || expr_tag == TAG_W'(TAG_NIL)) begin
                    val_d   = expr_q;
                    state_d = S_RETURN;
                end else if (expr_tag == TAG_W'(TAG_CONS)) begin
                    if (stk_full) begin
                        err_code_d = ERR_STACK_FULL;
                        state_d    = S_ERROR;
                    end else begin
                        push_frame.cur   = expr_pay[ADDR_W-1:0];
                        push_frame.first = 1'b1;
                        stk_push         = 1'b1;
                        state_d          = S_FETCH_OP;
                    end
                end else begin
                    err_code_d = ERR_BAD_TAG;
                    state_d    = S_ERROR;
                end
            end
            S_FETCH_OP: begin
                if (mem.mem_ready) begin
                    if (data_tag != TAG_W'(TAG_PRIM)) begin
                        err_code_d = ERR_NOT_PRIM;
                        state_d    = S_ERROR;
                    end else if (!prim_ok) begin
                        err_code_d = ERR_BAD_PRIM;
                        state_d    = S_ERROR;
                    end else begin
                        wr_frame.op  = data_pay[1:0];
                        wr_frame.acc = (data_pay == PAY_W'(PRIM_MUL)) ? PAY_W'(1) : '0;
                        stk_wr       = 1'b1;
                        state_d      = S_FETCH_CDR;
                    end
                end
            end
            S_FETCH_CDR: begin
                if (mem.mem_ready) begin
                    if (data_tag == TAG_W'(TAG_NIL)) begin
                        val_d   = {TAG_W'(TAG_INT), top_frame.acc};
                        stk_pop = 1'b1;
                        state_d = S_RETURN;
                    end else if (data_tag == TAG_W'(TAG_CONS)) begin
                        wr_frame.cur = data_pay[ADDR_W-1:0];
                        stk_wr       = 1'b1;
                        state_d      = S_FETCH_ARG;
                    end else begin
                        err_code_d = ERR_BAD_LIST;
                        state_d    = S_ERROR;
                    end
                end
            end
            S_FETCH_ARG: begin
                if (mem.mem_ready) begin
                    expr_d  = mem.mem_data;
                    state_d = S_EVAL;
                end
            end
            S_RETURN: begin
                if (stk_empty) begin
                    result_d = val_q;
                    state_d  = S_DONE;
                end else if (val_tag != TAG_W'(TAG_INT)) begin
                    err_code_d = ERR_NOT_INT;
                    state_d    = S_ERROR;
                end else begin
                    wr_frame.acc   = fold_acc;
                    wr_frame.first = 1'b0;
                    stk_wr         = 1'b1;
                    state_d        = S_FETCH_CDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request is a pure function of state, so rst drops it on the next cycle.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        result       = result_q;
        err_code     = err_code_q;
        case (state_q)
            S_EVAL, S_RETURN: busy = 1'b1;
            S_FETCH_OP, S_FETCH_ARG: begin
                busy         = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = top_frame.cur;
            end
            S_FETCH_CDR: begin
                busy         = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = top_frame.cur + ADDR_W'(1);
            end
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lisp_eval_engine.sv
// Directed bench: two evaluators (stack depth 8 and 2) sharing one word memory
// with random 1-5 cycle read latency; table of expressions plus corner sequences.
module tb_lisp_eval_engine;
    import lisp_defs::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] expr0 = '0, expr1 = '0;
    logic        busy0, done0, error0, busy1, done1, error1;
    logic [15:0] result0, err0, result1, err1;

    lisp_eval_engine_if #(.ADDR_W(13), .WORD_W(16)) m0 ();
    lisp_eval_engine_if #(.ADDR_W(13), .WORD_W(16)) m1 ();

    lisp_eval_engine #(.STACK_DEPTH(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .expr_in(expr0), .busy(busy0), .done(done0),
        .error(error0), .result(result0), .err_code(err0), .mem(m0)
    );
    lisp_eval_engine #(.STACK_DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .expr_in(expr1), .busy(busy1), .done(done1),
        .error(error1), .result(result1), .err_code(err1), .mem(m1)
    );

    logic [15:0] mem [256];
    logic        rdy0_q = 1'b0, rdy1_q = 1'b0, late0 = 1'b0;
    logic [15:0] dat0_q = '0, dat1_q = '0;
    int          cnt0 = 0, cnt1 = 0;

    assign m0.mem_ready = rdy0_q | late0;
    assign m0.mem_data  = dat0_q;
    assign m1.mem_ready = rdy1_q;
    assign m1.mem_data  = dat1_q;

    always @(posedge clk) begin
        if (rst || !m0.mem_req || rdy0_q) begin
            rdy0_q <= 1'b0;
            cnt0   <= int'($urandom_range(4, 0));
        end else if (cnt0 == 0) begin
            rdy0_q <= 1'b1;
            dat0_q <= mem[m0.mem_addr[7:0]];
        end else cnt0 <= cnt0 - 1;
    end

    always @(posedge clk) begin
        if (rst || !m1.mem_req || rdy1_q) begin
            rdy1_q <= 1'b0;
            cnt1   <= int'($urandom_range(4, 0));
        end else if (cnt1 == 0) begin
            rdy1_q <= 1'b1;
            dat1_q <= mem[m1.mem_addr[7:0]];
        end else cnt1 <= cnt1 - 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input bit sel, input logic [15:0] e,
                       output logic fin_err, output logic [15:0] val, output bit to);
        @(negedge clk);
        if (sel) begin start1 = 1'b1; expr1 = e; end
        else     begin start0 = 1'b1; expr0 = e; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (sel ? (done1 || error1) : (done0 || error0)) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        fin_err = sel ? error1 : error0;
        val     = sel ? (error1 ? err1 : result1) : (error0 ? err0 : result0);
    endtask

    typedef struct {
        logic [15:0] expr;
        logic        is_err;
        logic [15:0] val;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        f_err, seen;
        logic [15:0] f_val;
        bit          to;

        for (int i = 0; i < 256; i++) mem[i] = LISP_NIL;
        // (+ 3 4)
        mem[8'h10] = 16'h6000; mem[8'h11] = 16'h4012; mem[8'h12] = 16'h2003;
        mem[8'h13] = 16'h4014; mem[8'h14] = 16'h2004; mem[8'h15] = 16'h0000;
        // (- 10 (+ 2 3))
        mem[8'h20] = 16'h6001; mem[8'h21] = 16'h4022; mem[8'h22] = 16'h200A;
        mem[8'h23] = 16'h4024; mem[8'h24] = 16'h4026; mem[8'h25] = 16'h0000;
        mem[8'h26] = 16'h6000; mem[8'h27] = 16'h4028; mem[8'h28] = 16'h2002;
        mem[8'h29] = 16'h402A; mem[8'h2A] = 16'h2003; mem[8'h2B] = 16'h0000;
        // (+ 1FFF 1)
        mem[8'h30] = 16'h6000; mem[8'h31] = 16'h4032; mem[8'h32] = 16'h3FFF;
        mem[8'h33] = 16'h4034; mem[8'h34] = 16'h2001; mem[8'h35] = 16'h0000;
        // (* 3 4)
        mem[8'h38] = 16'h6002; mem[8'h39] = 16'h403A; mem[8'h3A] = 16'h2003;
        mem[8'h3B] = 16'h403C; mem[8'h3C] = 16'h2004; mem[8'h3D] = 16'h0000;
        // car is INT; then (+ . 5) with an INT cdr
        mem[8'h40] = 16'h2001;
        mem[8'h42] = 16'h6000; mem[8'h43] = 16'h2005;
        // (+ (+ (+ 1))) three frames deep
        mem[8'h50] = 16'h6000; mem[8'h51] = 16'h4052; mem[8'h52] = 16'h4054; mem[8'h53] = 16'h0000;
        mem[8'h54] = 16'h6000; mem[8'h55] = 16'h4056; mem[8'h56] = 16'h4058; mem[8'h57] = 16'h0000;
        mem[8'h58] = 16'h6000; mem[8'h59] = 16'h405A; mem[8'h5A] = 16'h2001; mem[8'h5B] = 16'h0000;
        // (-), (- 9), (+ nil), unknown prim 5, (+)
        mem[8'h60] = 16'h6001; mem[8'h61] = 16'h0000;
        mem[8'h62] = 16'h6001; mem[8'h63] = 16'h4064; mem[8'h64] = 16'h2009; mem[8'h65] = 16'h0000;
        mem[8'h66] = 16'h6000; mem[8'h67] = 16'h4068; mem[8'h68] = 16'h0000; mem[8'h69] = 16'h0000;
        mem[8'h6A] = 16'h6005; mem[8'h6B] = 16'h0000;
        mem[8'h6C] = 16'h6000; mem[8'h6D] = 16'h0000;

        vecs.push_back('{16'h4010, 1'b0, 16'h2007});
        vecs.push_back('{16'h4020, 1'b0, 16'h2005});
        vecs.push_back('{16'h4030, 1'b0, 16'h2000});
        vecs.push_back('{16'h4050, 1'b0, 16'h2001});
        vecs.push_back('{16'h4060, 1'b0, 16'h2000});
        vecs.push_back('{16'h4062, 1'b0, 16'h2009});
        vecs.push_back('{16'h406C, 1'b0, 16'h2000});
        vecs.push_back('{16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{16'h8005, 1'b1, 16'hE001});
        vecs.push_back('{16'h4040, 1'b1, 16'hE002});
        vecs.push_back('{16'h406A, 1'b1, 16'hE003});
        vecs.push_back('{16'h4042, 1'b1, 16'hE004});
        vecs.push_back('{16'h4066, 1'b1, 16'hE005});
`ifdef LISP_EVAL_MUL_EN
        vecs.push_back('{16'h4038, 1'b0, 16'h200C});
`else
        vecs.push_back('{16'h4038, 1'b1, 16'hE003});
`endif

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dut0", {busy0, done0, error0, m0.mem_req, result0, err0, m0.mem_addr}, 64'h0);
        chk("reset_dut1", {busy1, done1, error1, m1.mem_req, result1, err1, m1.mem_addr}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Atom root: done on the third edge counting the sampling edge, no memory traffic
        start0 = 1'b1;
        expr0  = 16'h2005;
        @(negedge clk);
        start0 = 1'b0;
        seen   = m0.mem_req;
        chk("atom_busy_c1", {busy0, done0}, 2'b10);
        @(negedge clk);
        seen = seen | m0.mem_req;
        chk("atom_busy_c2", {busy0, done0}, 2'b10);
        @(negedge clk);
        seen = seen | m0.mem_req;
        chk("atom_done_c3", {busy0, done0, error0, result0}, {3'b010, 16'h2005});
        chk("atom_no_mem", seen, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            run(1'b0, vecs[i].expr, f_err, f_val, to);
            chk($sformatf("v%0d_timeout", i), to, 1'b0);
            chk($sformatf("v%0d_status", i), f_err, vecs[i].is_err);
            chk($sformatf("v%0d_value", i), f_val, vecs[i].val);
            if (!vecs[i].is_err)
                chk($sformatf("v%0d_errcode_clear", i), err0, 16'h0);
            chk($sformatf("v%0d_exclusive", i), {done0, error0}, vecs[i].is_err ? 2'b01 : 2'b10);
        end

        // DONE holds its result while idle
        run(1'b0, 16'h4010, f_err, f_val, to);
        repeat (5) @(negedge clk);
        chk("done_hold", {busy0, done0, error0, result0}, {3'b010, 16'h2007});

        // Shallow stack: three-deep nesting overflows, one-deep still works
        run(1'b1, 16'h4050, f_err, f_val, to);
        chk("depth2_timeout", to, 1'b0);
        chk("depth2_overflow", {f_err, f_val}, {1'b1, 16'hE006});
        run(1'b1, 16'h4010, f_err, f_val, to);
        chk("depth2_simple", {to, f_err, f_val}, {2'b00, 16'h2007});

        // Reset while a read is outstanding
        @(negedge clk);
        start0 = 1'b1;
        expr0  = 16'h4010;
        @(negedge clk);
        start0 = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (m0.mem_req) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("rst_req_seen", to, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {busy0, done0, error0, m0.mem_req, result0, err0, m0.mem_addr}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        late0 = 1'b1;
        @(negedge clk);
        late0 = 1'b0;
        @(negedge clk);
        chk("late_ready_ignored", {busy0, done0, error0, m0.mem_req, result0, err0}, 64'h0);
        run(1'b0, 16'h4010, f_err, f_val, to);
        chk("rerun_after_rst", {to, f_err, f_val}, {2'b00, 16'h2007});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
